// File: rtl/channel_allocator_if.sv
// Request/grant bundle between the route-compute requesters and the channel allocator.
interface channel_allocator_if #(
    parameter int unsigned N    = 10,
    parameter int unsigned SELW = 4
);
    logic [N*N-1:0]    req_flat;
    logic [N*N-1:0]    gnt_flat;
    logic [N*SELW-1:0] sel_flat;
    logic [N-1:0]      busy;

    modport master (output req_flat, input gnt_flat, input sel_flat, input busy);
    modport slave  (input req_flat, output gnt_flat, output sel_flat, output busy);
endinterface

// File: rtl/channel_allocator.sv
// Per-channel round-robin allocator with wormhole locking: a channel stays with
// its owner until the owner's request moves away, then passes on without a bubble.
module channel_allocator #(
    parameter int unsigned N    = 10,
    parameter int unsigned SELW = 4
) (
    input  logic                clk,
    input  logic                rst,
    channel_allocator_if.slave  bus
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } chan_state_e;

    chan_state_e      state_q [N];
    chan_state_e      state_d [N];
    logic [SELW-1:0]  owner_q [N];
    logic [SELW-1:0]  owner_d [N];
    logic [SELW-1:0]  ptr_q   [N];
    logic [SELW-1:0]  ptr_d   [N];
    logic [N*N-1:0]   gnt_q;
    logic [N*N-1:0]   gnt_d;

    logic [N-1:0]     eff_req  [N];
    logic [N-1:0]     chan_req [N];

    // Keep only each requester's lowest channel bit, then transpose to per-channel views.
    always_comb begin
        for (int r = 0; r < int'(N); r++) begin
            eff_req[r] = bus.req_flat[r*N +: N] & (~bus.req_flat[r*N +: N] + N'(1));
        end
        for (int c = 0; c < int'(N); c++) begin
            chan_req[c] = '0;
            for (int r = 0; r < int'(N); r++) begin
                chan_req[c][r] = eff_req[r][c];
            end
        end
    end

    // Per-channel hold/release decision and rotating-priority search from ptr.
    always_comb begin : p_next
        logic            found;
        int              idx;
        logic [SELW-1:0] idx_s;
        found = 1'b0;
        idx   = 0;
        idx_s = '0;
        for (int c = 0; c < int'(N); c++) begin
            state_d[c] = state_q[c];
            owner_d[c] = owner_q[c];
            ptr_d[c]   = ptr_q[c];
            if (state_q[c] == ST_IDLE || !chan_req[c][owner_q[c]]) begin
                // A releasing owner no longer requests c, so it drops out of the search.
                state_d[c] = ST_IDLE;
                found      = 1'b0;
                for (int k = 0; k < int'(N); k++) begin
                    idx = int'(ptr_q[c]) + k;
                    if (idx >= int'(N)) begin
                        idx = idx - int'(N);
                    end
                    idx_s = SELW'(idx);
                    if (!found && chan_req[c][idx_s]) begin
                        found      = 1'b1;
                        state_d[c] = ST_OWNED;
                        owner_d[c] = idx_s;
                        ptr_d[c]   = (idx == int'(N) - 1) ? '0 : SELW'(idx + 1);
                    end
                end
            end
        end
        gnt_d = '0;
        for (int r = 0; r < int'(N); r++) begin
            for (int c = 0; c < int'(N); c++) begin
                gnt_d[r*N + c] = (state_d[c] == ST_OWNED) && (owner_d[c] == SELW'(r));
            end
        end
    end

    // State, owner, pointer and grant registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < int'(N); c++) begin
                state_q[c] <= ST_IDLE;
                owner_q[c] <= '0;
                ptr_q[c]   <= '0;
            end
            gnt_q <= '0;
        end else begin
            for (int c = 0; c < int'(N); c++) begin
                state_q[c] <= state_d[c];
                owner_q[c] <= owner_d[c];
                ptr_q[c]   <= ptr_d[c];
            end
            gnt_q <= gnt_d;
        end
    end

    // Drive the bus from registered state; select holds the last owner while idle.
    always_comb begin
        bus.gnt_flat = gnt_q;
        bus.sel_flat = '0;
        bus.busy     = '0;
        for (int c = 0; c < int'(N); c++) begin
            bus.sel_flat[c*SELW +: SELW] = owner_q[c];
            bus.busy[c]                  = (state_q[c] == ST_OWNED);
        end
    end

endmodule

// File: tb/tb_channel_allocator.sv
// Bench for channel_allocator: directed scenarios plus random traffic against a reference model.
module tb_channel_allocator;

    localparam int unsigned N    = 10;
    localparam int unsigned SELW = 4;

    logic clk;
    logic rst;

    channel_allocator_if #(.N(N), .SELW(SELW)) bus ();

    channel_allocator #(.N(N), .SELW(SELW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: per-channel ownership by rule, not by state machine.
    int m_busy  [N];
    int m_owner [N];
    int m_ptr   [N];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int c = 0; c < int'(N); c++) begin
            m_busy[c] = 0; m_owner[c] = 0; m_ptr[c] = 0;
        end
    endtask

    // One clock edge: winner is the requester with smallest rotational distance from ptr.
    task automatic model_edge(input logic [N*N-1:0] req);
        int eff [N];
        int best, bestd, d;
        for (int r = 0; r < int'(N); r++) begin
            eff[r] = -1;
            for (int c = 0; c < int'(N); c++)
                if (eff[r] < 0 && req[r*N + c]) eff[r] = c;
        end
        for (int c = 0; c < int'(N); c++) begin
            if (m_busy[c] != 0 && eff[m_owner[c]] == c) continue;
            best = -1; bestd = N;
            for (int r = 0; r < int'(N); r++) begin
                if (eff[r] == c) begin
                    d = (r - m_ptr[c] + int'(N)) % int'(N);
                    if (d < bestd) begin bestd = d; best = r; end
                end
            end
            if (best >= 0) begin
                m_busy[c] = 1; m_owner[c] = best; m_ptr[c] = (best + 1) % int'(N);
            end else begin
                m_busy[c] = 0;
            end
        end
    endtask

    function automatic logic [N*N-1:0] exp_gnt();
        logic [N*N-1:0] v = '0;
        for (int c = 0; c < int'(N); c++)
            if (m_busy[c] != 0) v[m_owner[c]*N + c] = 1'b1;
        return v;
    endfunction

    function automatic logic [N*SELW-1:0] exp_sel();
        logic [N*SELW-1:0] v = '0;
        for (int c = 0; c < int'(N); c++) v[c*SELW +: SELW] = SELW'(m_owner[c]);
        return v;
    endfunction

    function automatic logic [N-1:0] exp_busy();
        logic [N-1:0] v = '0;
        for (int c = 0; c < int'(N); c++) v[c] = (m_busy[c] != 0);
        return v;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".gnt"},  bus.gnt_flat, exp_gnt());
        check({tag, ".sel"},  bus.sel_flat, exp_sel());
        check({tag, ".busy"}, bus.busy,     exp_busy());
    endtask

    task automatic step(input string tag);
        model_edge(bus.req_flat);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_flat = '0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all("reset");
    endtask

    initial begin
        int cnt [N];
        int order [$];
        int prev, cyc, ord;
        logic [N-1:0] row;

        rst = 1'b1;
        bus.req_flat = '0;
        model_reset();
        #1;
        check_all("reset_async");
        do_reset();

        // Single request: r3 -> ch5
        bus.req_flat[3*N + 5] = 1'b1;
        step("single");
        check("single.gnt35", bus.gnt_flat, (N*N)'(1) << 35);
        check("single.busy5", bus.busy[5], 1'b1);
        check("single.sel5", bus.sel_flat[5*SELW +: SELW], 4'd3);

        // Contention on ch2 from r1, r4, r7; each holds three granted cycles
        do_reset();
        bus.req_flat[1*N + 2] = 1'b1;
        bus.req_flat[4*N + 2] = 1'b1;
        bus.req_flat[7*N + 2] = 1'b1;
        for (int i = 0; i < int'(N); i++) cnt[i] = 0;
        prev = -1;
        cyc  = 0;
        while ((bus.req_flat[1*N+2] | bus.req_flat[4*N+2] | bus.req_flat[7*N+2]) && cyc < 40) begin
            step("contend");
            cyc++;
            for (int r = 1; r < 8; r += 3) begin
                if (bus.gnt_flat[r*N + 2]) begin
                    cnt[r]++;
                    if (prev != r) begin order.push_back(r); prev = r; end
                    if (cnt[r] == 3) bus.req_flat[r*N + 2] = 1'b0;
                end
            end
            if (bus.req_flat[1*N+2] | bus.req_flat[4*N+2] | bus.req_flat[7*N+2])
                check("contend.no_bubble", bus.busy[2], 1'b1);
        end
        check("contend.timeout", (cyc >= 40), 1'b0);
        ord = (order.size() == 3) ? (order[0]*256 + order[1]*16 + order[2]) : 32'hFFF;
        check("contend.order", ord, 'h147);
        step("contend.idle");
        // ptr should now be 8: r8 beats r0
        bus.req_flat[0*N + 2] = 1'b1;
        bus.req_flat[8*N + 2] = 1'b1;
        step("contend.ptr");
        check("contend.ptr8", bus.gnt_flat[8*N + 2], 1'b1);

        // Lock: r0 holds ch0 against r2
        do_reset();
        bus.req_flat[0] = 1'b1;
        step("lock.grant");
        bus.req_flat[2*N] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step("lock.hold");
            check("lock.r0", bus.gnt_flat[0], 1'b1);
        end
        bus.req_flat[0] = 1'b0;
        step("lock.pass");
        check("lock.r2", bus.gnt_flat[2*N], 1'b1);
        check("lock.sel0", bus.sel_flat[0 +: SELW], 4'd2);

        // Multi-bit request: only lowest channel granted
        do_reset();
        bus.req_flat[6*N + 1] = 1'b1;
        bus.req_flat[6*N + 9] = 1'b1;
        step("multi");
        check("multi.ch1", bus.gnt_flat[6*N + 1], 1'b1);
        check("multi.busy9", bus.busy[9], 1'b0);

        // Parallel grants, then async reset with four channels busy
        do_reset();
        bus.req_flat[0*N + 3] = 1'b1;
        bus.req_flat[5*N + 8] = 1'b1;
        bus.req_flat[9*N + 0] = 1'b1;
        step("par");
        check("par.busy", bus.busy, N'(10'b01_0000_1001));
        check("par.sel3", bus.sel_flat[3*SELW +: SELW], 4'd0);
        check("par.sel8", bus.sel_flat[8*SELW +: SELW], 4'd5);
        check("par.sel0", bus.sel_flat[0*SELW +: SELW], 4'd9);
        bus.req_flat[2*N + 6] = 1'b1;
        step("par4");
        #2;
        rst = 1'b1;
        #1;
        check("rstmid.gnt", bus.gnt_flat, '0);
        check("rstmid.busy", bus.busy, '0);
        model_reset();
        bus.req_flat = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all("rstmid.after");
        bus.req_flat[9*N + 4] = 1'b1;
        bus.req_flat[0*N + 4] = 1'b1;
        step("rstmid.arb");
        check("rstmid.r0wins", bus.gnt_flat[4], 1'b1);

        // Random traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            for (int r = 0; r < int'(N); r++) begin
                if ($urandom_range(3) == 0) begin
                    case ($urandom_range(3))
                        0:       row = '0;
                        1, 2:    row = N'(1) << $urandom_range(N - 1);
                        default: row = N'($urandom);
                    endcase
                    bus.req_flat[r*N +: N] = row;
                end
            end
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
